i2c_eeprom_seq: RTL and testbench
=================================

Name: i2c_eeprom_seq

Overview:
Transaction sequencer that drives the byte-level I2C engine (i2c_module) to perform complete EEPROM transfers: page write, address-only write (ACK polling) and single-byte random read. It sits between the bottomhalf command decoder and the engine. It supplies each byte's controls, checks ACKs, aborts cleanly on NACK or timeout, and holds the engine in reset while idle so that the engine's free-running byte loop stays parked.

Parameters:
ADDR_BYTES, 2, number of memory-address bytes sent (1 or 2; with 1, only cmd_addr[7:0] is sent)
MAX_LEN, 16, maximum write burst length (page size)
TIMEOUT, 96, clock cycles allowed between engine finished pulses before abort

Ports:
clock  in  1  system clock
nreset  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE; a command is accepted when cmd_valid&&cmd_ready
cmd_read  in  1  1=random read of one byte, 0=write
cmd_dev  in  7  7-bit device address
cmd_addr  in  16  memory address
cmd_len  in  5  write byte count (0=address-only, clamped to MAX_LEN)
wr_data  in  8  show-ahead write data from host FIFO
wr_pop  out  1  one-cycle strobe: wr_data consumed; host advances the FIFO
rd_data  out  8  read result
rd_valid  out  1  one-cycle strobe with rd_data
busy  out  1  high from command accept until done
done  out  1  one-cycle strobe at the end of every command
err_nack  out  1  sticky until next accept: a write byte was NACKed
err_timeout  out  1  sticky until next accept: engine watchdog expired
eng_nreset  out  1  engine reset, active-low
eng_write_byte  out  8  engine byte
eng_read_mode  out  1  engine read_mode
eng_do_start  out  1  engine do_start
eng_do_stop  out  1  engine do_stop
eng_finished  in  1  engine finished pulse
eng_ack  in  1  engine ack (0=ACK)
eng_read_byte  in  8  engine read_byte

Behaviour:
- Reset (nreset=0 at a clock edge): state IDLE; eng_nreset=0, all eng_* controls 0, cmd_ready=1, busy=0, rd_data=0, all strobes 0, err flags 0, timer 0, counters 0.
- Engine contract: the engine starts its next byte in the cycle after a finished pulse, using the controls present then. All eng_* control outputs are registered and are updated in the same cycle that eng_finished is seen. eng_ack and eng_read_byte are sampled only in finished cycles.
- States: IDLE, LAUNCH, DEV_W, ADDR, WDATA, DEV_R, RDATA, ABORT, DONE.
- IDLE: eng_nreset=0. On accept: latch the command, clear err flags, busy=1, and load the controls {byte={dev,0}, start=1, stop=(len==0 && ADDR_BYTES==0 is impossible)→0, read_mode=0}. Go to LAUNCH.
- LAUNCH: eng_nreset=1 for one cycle, then DEV_W.
- DEV_W/ADDR/WDATA/DEV_R: on finished, if eng_ack=1, go to ABORT. Otherwise load the next byte per this sequence:
  - Write: dev(W), addr hi (only when ADDR_BYTES=2), addr lo, then len data bytes. do_stop=1 on the final byte. With len=0, the final address byte carries the stop.
  - Read: dev(W), addr bytes, then dev(R) with do_start=1 (repeated start), then one read byte with read_mode=1, do_stop=1.
- WDATA: load wr_data into eng_write_byte and pulse wr_pop in the same cycle. The byte count decrements with wrap protection: the count never goes below 0.
- RDATA: on finished, capture eng_read_byte into rd_data, pulse rd_valid next cycle, go to DONE. eng_ack is ignored because there is no master ACK.
- After the finished pulse of a byte sent with do_stop, go to DONE.
- ABORT: load controls read_mode=1, do_stop=1, start=0 (dummy read that releases SDA and then issues STOP). Set err_nack. On its finished pulse, go to DONE. The dummy byte is discarded.
- Watchdog: the timer clears on every finished pulse and on accept, and counts while busy. At TIMEOUT it sets err_timeout and goes directly to DONE (engine reset releases the bus, no STOP).
- DONE: eng_nreset=0, done pulses one cycle, busy=0, then IDLE. Latency from accept to engine release: 2 cycles.
- cmd_valid while busy is ignored (cmd_ready=0). cmd_len>MAX_LEN is clamped to MAX_LEN. If NACK and timeout fall in the same cycle, timeout wins and err_nack is not set.
- Reset mid-transfer: the engine is reset immediately, and no done or strobes are issued.

Test Plan:
- Write dev=0x50, addr=0x0123, len=2, data 0xA5,0x5A, engine model ACKs all -> bytes 0xA0,0x01,0x23,0xA5,0x5A; start only on the first byte; stop only on 0x5A; wr_pop pulses twice; done once; no errors.
- Read dev=0x50, addr=0x0010, device returns 0x3C -> bytes 0xA0,0x00,0x10, then 0xA1 with do_start=1, then read_mode byte with stop; rd_data=0x3C with rd_valid one pulse; done.
- Write with NACK on the device byte -> ABORT dummy read with stop, err_nack=1, no wr_pop, done one pulse; next accept clears err_nack.
- Engine model never asserts finished -> err_timeout=1 TIMEOUT cycles after LAUNCH, eng_nreset=0, done one pulse.
- len=0 and len=20 writes -> len=0: stop on the addr lo byte with zero wr_pop; len=20: exactly 16 data bytes.
- nreset low during WDATA, with cmd_valid held high during busy -> all outputs at reset values next cycle; the held command is accepted only after IDLE returns.

Source files
------------

// File: rtl/i2c_eeprom_seq.sv
// EEPROM transaction sequencer: walks the byte-level I2C engine through page write,
// address-only write and single-byte random read, with NACK abort and a finished-pulse watchdog.
module i2c_eeprom_seq #(
    parameter int unsigned ADDR_BYTES = 2,
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned TIMEOUT    = 96
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [6:0]  cmd_dev,
    input  logic [15:0] cmd_addr,
    input  logic [4:0]  cmd_len,
    input  logic [7:0]  wr_data,
    output logic        wr_pop,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        err_nack,
    output logic        err_timeout,
    output logic        eng_nreset,
    output logic [7:0]  eng_write_byte,
    output logic        eng_read_mode,
    output logic        eng_do_start,
    output logic        eng_do_stop,
    input  logic        eng_finished,
    input  logic        eng_ack,
    input  logic [7:0]  eng_read_byte
);

    localparam int unsigned LEN_W = 5;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam bit TWO_ADDR = (ADDR_BYTES == 2);

    typedef enum logic [3:0] {
        S_IDLE, S_LAUNCH, S_DEV_W, S_ADDR, S_WDATA, S_DEV_R, S_RDATA, S_ABORT, S_DONE
    } state_t;

    state_t             r_state;
    logic               r_read;
    logic [6:0]         r_dev;
    logic [15:0]        r_addr;
    logic [LEN_W-1:0]   r_len;
    logic               r_lo_pending;
    logic [TMR_W-1:0]   r_timer;
    logic               r_cmd_ready;
    logic               r_wr_pop;
    logic [7:0]         r_rd_data;
    logic               r_rd_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_err_nack;
    logic               r_err_timeout;
    logic               r_eng_nreset;
    logic [7:0]         r_byte;
    logic               r_rmode;
    logic               r_start;
    logic               r_stop;

    logic w_accept;
    logic w_counting;
    logic w_byte_state;
    logic w_expire;
    logic w_nack;
    logic w_fin_done;
    logic w_go_done;

    assign w_accept     = cmd_valid && r_cmd_ready;
    assign w_counting   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_byte_state = (r_state == S_DEV_W) || (r_state == S_ADDR) ||
                          (r_state == S_WDATA) || (r_state == S_DEV_R);
    assign w_expire     = w_counting && (r_timer == TMR_LAST);
    assign w_nack       = !w_expire && eng_finished && w_byte_state && eng_ack;
    // A finished pulse ends the command after a stop byte, the read byte, or the abort dummy read
    assign w_fin_done   = !w_expire && eng_finished &&
                          ((w_byte_state && !eng_ack && r_stop) ||
                           (r_state == S_RDATA) || (r_state == S_ABORT));
    assign w_go_done    = w_expire || w_fin_done;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state       <= S_IDLE;
            r_read        <= 1'b0;
            r_dev         <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_lo_pending  <= 1'b0;
            r_timer       <= '0;
            r_cmd_ready   <= 1'b1;
            r_wr_pop      <= 1'b0;
            r_rd_data     <= '0;
            r_rd_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_nack    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_eng_nreset  <= 1'b0;
            r_byte        <= '0;
            r_rmode       <= 1'b0;
            r_start       <= 1'b0;
            r_stop        <= 1'b0;
        end else begin
            r_wr_pop   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_read        <= cmd_read;
                        r_dev         <= cmd_dev;
                        r_addr        <= cmd_addr;
                        r_len         <= (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
                        r_lo_pending  <= 1'b0;
                        r_err_nack    <= 1'b0;
                        r_err_timeout <= 1'b0;
                        r_busy        <= 1'b1;
                        r_cmd_ready   <= 1'b0;
                        r_timer       <= '0;
                        r_byte        <= {cmd_dev, 1'b0};
                        r_start       <= 1'b1;
                        r_stop        <= 1'b0;
                        r_rmode       <= 1'b0;
                        r_state       <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    r_eng_nreset <= 1'b1;
                    r_timer      <= r_timer + TMR_W'(1);
                    r_state      <= S_DEV_W;
                end

                S_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    if (eng_finished) r_timer <= '0;
                    else              r_timer <= r_timer + TMR_W'(1);

                    if (w_expire) begin
                        r_err_timeout <= 1'b1;
                    end else if (w_nack) begin
                        // Dummy read releases SDA so the engine can issue STOP
                        r_err_nack <= 1'b1;
                        r_byte     <= 8'hFF;
                        r_rmode    <= 1'b1;
                        r_start    <= 1'b0;
                        r_stop     <= 1'b1;
                        r_state    <= S_ABORT;
                    end else if (eng_finished && !w_fin_done) begin
                        case (r_state)
                            S_DEV_W: begin
                                r_start <= 1'b0;
                                r_state <= S_ADDR;
                                if (TWO_ADDR) begin
                                    r_byte       <= r_addr[15:8];
                                    r_stop       <= 1'b0;
                                    r_lo_pending <= 1'b1;
                                end else begin
                                    r_byte       <= r_addr[7:0];
                                    r_stop       <= !r_read && (r_len == '0);
                                    r_lo_pending <= 1'b0;
                                end
                            end
                            S_ADDR: begin
                                if (r_lo_pending) begin
                                    r_byte       <= r_addr[7:0];
                                    r_stop       <= !r_read && (r_len == '0);
                                    r_lo_pending <= 1'b0;
                                end else if (r_read) begin
                                    r_byte  <= {r_dev, 1'b1};
                                    r_start <= 1'b1;
                                    r_stop  <= 1'b0;
                                    r_state <= S_DEV_R;
                                end else begin
                                    r_byte   <= wr_data;
                                    r_wr_pop <= 1'b1;
                                    r_stop   <= (r_len == LEN_W'(1));
                                    r_len    <= (r_len == '0) ? '0 : r_len - LEN_W'(1);
                                    r_state  <= S_WDATA;
                                end
                            end
                            S_WDATA: begin
                                r_byte   <= wr_data;
                                r_wr_pop <= 1'b1;
                                r_stop   <= (r_len == LEN_W'(1));
                                r_len    <= (r_len == '0) ? '0 : r_len - LEN_W'(1);
                            end
                            S_DEV_R: begin
                                r_byte  <= 8'hFF;
                                r_rmode <= 1'b1;
                                r_start <= 1'b0;
                                r_stop  <= 1'b1;
                                r_state <= S_RDATA;
                            end
                            default: begin
                            end
                        endcase
                    end

                    if (w_fin_done && (r_state == S_RDATA)) begin
                        r_rd_data  <= eng_read_byte;
                        r_rd_valid <= 1'b1;
                    end
                end
            endcase

            // Holding the engine in reset parks its byte loop and releases the bus
            if (w_go_done) begin
                r_state      <= S_DONE;
                r_eng_nreset <= 1'b0;
                r_byte       <= '0;
                r_rmode      <= 1'b0;
                r_start      <= 1'b0;
                r_stop       <= 1'b0;
                r_lo_pending <= 1'b0;
                r_timer      <= '0;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
            end
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign wr_pop         = r_wr_pop;
    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err_nack       = r_err_nack;
    assign err_timeout    = r_err_timeout;
    assign eng_nreset     = r_eng_nreset;
    assign eng_write_byte = r_byte;
    assign eng_read_mode  = r_rmode;
    assign eng_do_start   = r_start;
    assign eng_do_stop    = r_stop;

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// Directed bench for i2c_eeprom_seq: a behavioural byte engine logs the controls of every
// byte it starts, and the sequence is compared against hand-computed EEPROM transfers.
module tb_i2c_eeprom_seq;

    localparam int BYTE_CYC = 4;
    localparam int TIMEOUT  = 96;

    logic        clock = 1'b0;
    logic        nreset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [6:0]  cmd_dev;
    logic [15:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic [7:0]  wr_data;
    logic        wr_pop;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        err_nack;
    logic        err_timeout;
    logic        eng_nreset;
    logic [7:0]  eng_write_byte;
    logic        eng_read_mode;
    logic        eng_do_start;
    logic        eng_do_stop;
    logic        eng_finished;
    logic        eng_ack;
    logic [7:0]  eng_read_byte;

    always #5 clock = ~clock;

    i2c_eeprom_seq #(.ADDR_BYTES(2), .MAX_LEN(16), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .nreset(nreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_dev(cmd_dev), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .err_nack(err_nack), .err_timeout(err_timeout),
        .eng_nreset(eng_nreset), .eng_write_byte(eng_write_byte),
        .eng_read_mode(eng_read_mode), .eng_do_start(eng_do_start),
        .eng_do_stop(eng_do_stop), .eng_finished(eng_finished),
        .eng_ack(eng_ack), .eng_read_byte(eng_read_byte)
    );

    // Engine model state; log entry = {read_mode, do_start, do_stop, byte}
    logic [10:0] e_log [0:63];
    int          e_n = 0;
    int          e_cnt = 0;
    bit          e_active = 1'b0;
    bit          e_hang = 1'b0;
    int          e_nack_idx = -1;
    logic [7:0]  e_rd_val = 8'h00;

    logic [7:0]  wq [0:31];
    int          widx = 0;
    int          n_pop = 0;
    int          n_done = 0;
    int          n_rdv = 0;
    logic [7:0]  last_rd = 8'h00;

    int          n_cmp = 0;
    int          n_fail = 0;

    // Byte engine: starts a byte when released or the cycle after finished, finishes BYTE_CYC later
    always @(negedge clock) begin
        if (eng_nreset !== 1'b1) begin
            e_active     = 1'b0;
            e_cnt        = 0;
            eng_finished = 1'b0;
        end else if (!e_active || eng_finished) begin
            eng_finished = 1'b0;
            e_active     = 1'b1;
            e_cnt        = 0;
            if (e_n < 64) e_log[e_n] = {eng_read_mode, eng_do_start, eng_do_stop, eng_write_byte};
            e_n++;
        end else begin
            e_cnt++;
            if (e_cnt == BYTE_CYC && !e_hang) begin
                eng_finished  = 1'b1;
                eng_ack       = ((e_n - 1) == e_nack_idx);
                eng_read_byte = e_rd_val;
            end
        end
    end

    // Host side: show-ahead FIFO plus strobe counters
    always @(negedge clock) begin
        if (wr_pop === 1'b1) begin
            n_pop++;
            widx++;
            if (widx < 32) wr_data = wq[widx];
        end
        if (done === 1'b1) n_done++;
        if (rd_valid === 1'b1) begin
            n_rdv++;
            last_rd = rd_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model(input int nack_idx, input bit hang, input logic [7:0] rv);
        e_n        = 0;
        e_nack_idx = nack_idx;
        e_hang     = hang;
        e_rd_val   = rv;
        n_pop      = 0;
        n_done     = 0;
        n_rdv      = 0;
        last_rd    = 8'h00;
        widx       = 0;
        wr_data    = wq[0];
    endtask

    task automatic send(input bit rd, input logic [6:0] dev, input logic [15:0] addr,
                        input logic [4:0] len, input bit hold);
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_dev   = dev;
        cmd_addr  = addr;
        cmd_len   = len;
        @(posedge clock); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        repeat (4) @(negedge clock);
    endtask

    initial begin
        nreset        = 1'b0;
        cmd_valid     = 1'b0;
        cmd_read      = 1'b0;
        cmd_dev       = '0;
        cmd_addr      = '0;
        cmd_len       = '0;
        eng_finished  = 1'b0;
        eng_ack       = 1'b0;
        eng_read_byte = '0;
        for (int i = 0; i < 32; i++) wq[i] = 8'h00;
        wr_data = 8'h00;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_eng_nreset", 32'(eng_nreset), 32'd0);
        chk("rst_ctrl", {20'd0, eng_read_mode, eng_do_start, eng_do_stop, eng_write_byte}, 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_strobes", {29'd0, done, wr_pop, rd_valid}, 32'd0);
        chk("rst_errs", {30'd0, err_nack, err_timeout}, 32'd0);
        nreset = 1'b1;

        // Page write of two bytes
        wq[0] = 8'hA5;
        wq[1] = 8'h5A;
        clear_model(-1, 1'b0, 8'h00);
        send(1'b0, 7'h50, 16'h0123, 5'd2, 1'b0);
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("wr_launch_nreset", 32'(eng_nreset), 32'd0);
        @(posedge clock); #1;
        chk("wr_release", 32'(eng_nreset), 32'd1);
        chk("wr_first_ctrl", {21'd0, eng_read_mode, eng_do_start, eng_do_stop, eng_write_byte},
            {21'd0, 3'b010, 8'hA0});
        wait_done("wr");
        chk("wr_nbytes", 32'(e_n), 32'd5);
        chk("wr_b0", 32'(e_log[0]), {21'd0, 3'b010, 8'hA0});
        chk("wr_b1", 32'(e_log[1]), {21'd0, 3'b000, 8'h01});
        chk("wr_b2", 32'(e_log[2]), {21'd0, 3'b000, 8'h23});
        chk("wr_b3", 32'(e_log[3]), {21'd0, 3'b000, 8'hA5});
        chk("wr_b4", 32'(e_log[4]), {21'd0, 3'b001, 8'h5A});
        chk("wr_pops", 32'(n_pop), 32'd2);
        chk("wr_dones", 32'(n_done), 32'd1);
        chk("wr_errs", {30'd0, err_nack, err_timeout}, 32'd0);
        chk("wr_idle", {29'd0, busy, cmd_ready, eng_nreset}, {29'd0, 3'b010});

        // Random read of one byte
        clear_model(-1, 1'b0, 8'h3C);
        send(1'b1, 7'h50, 16'h0010, 5'd0, 1'b0);
        wait_done("rd");
        chk("rd_nbytes", 32'(e_n), 32'd5);
        chk("rd_b0", 32'(e_log[0]), {21'd0, 3'b010, 8'hA0});
        chk("rd_b1", 32'(e_log[1]), {21'd0, 3'b000, 8'h00});
        chk("rd_b2", 32'(e_log[2]), {21'd0, 3'b000, 8'h10});
        chk("rd_b3", 32'(e_log[3]), {21'd0, 3'b010, 8'hA1});
        chk("rd_b4_ctrl", 32'(e_log[4][10:8]), 32'b101);
        chk("rd_data", 32'(rd_data), 32'h3C);
        chk("rd_valid_cnt", 32'(n_rdv), 32'd1);
        chk("rd_valid_data", 32'(last_rd), 32'h3C);
        chk("rd_pops", 32'(n_pop), 32'd0);
        chk("rd_dones", 32'(n_done), 32'd1);

        // NACK on the device byte
        clear_model(0, 1'b0, 8'h00);
        send(1'b0, 7'h50, 16'h0123, 5'd2, 1'b0);
        wait_done("nack");
        chk("nack_nbytes", 32'(e_n), 32'd2);
        chk("nack_b0", 32'(e_log[0]), {21'd0, 3'b010, 8'hA0});
        chk("nack_abort_ctrl", 32'(e_log[1][10:8]), 32'b101);
        chk("nack_err", 32'(err_nack), 32'd1);
        chk("nack_no_timeout", 32'(err_timeout), 32'd0);
        chk("nack_pops", 32'(n_pop), 32'd0);
        chk("nack_dones", 32'(n_done), 32'd1);

        // Address-only write; its accept clears err_nack
        clear_model(-1, 1'b0, 8'h00);
        send(1'b0, 7'h50, 16'h0123, 5'd0, 1'b0);
        chk("len0_nack_cleared", 32'(err_nack), 32'd0);
        wait_done("len0");
        chk("len0_nbytes", 32'(e_n), 32'd3);
        chk("len0_b1", 32'(e_log[1]), {21'd0, 3'b000, 8'h01});
        chk("len0_b2", 32'(e_log[2]), {21'd0, 3'b001, 8'h23});
        chk("len0_pops", 32'(n_pop), 32'd0);
        chk("len0_dones", 32'(n_done), 32'd1);

        // Engine never finishes: watchdog
        clear_model(-1, 1'b1, 8'h00);
        send(1'b0, 7'h50, 16'h0123, 5'd2, 1'b0);
        repeat (TIMEOUT - 1) @(posedge clock);
        #1;
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        chk("to_busy_before", 32'(busy), 32'd1);
        @(posedge clock); #1;
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_done", 32'(done), 32'd1);
        chk("to_eng_nreset", 32'(eng_nreset), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_no_nack", 32'(err_nack), 32'd0);
        repeat (4) @(negedge clock);
        chk("to_dones", 32'(n_done), 32'd1);

        // Oversized burst is clamped to 16 data bytes
        for (int i = 0; i < 32; i++) wq[i] = 8'h10 + 8'(i);
        clear_model(-1, 1'b0, 8'h00);
        send(1'b0, 7'h50, 16'h0123, 5'd20, 1'b0);
        wait_done("len20");
        chk("len20_nbytes", 32'(e_n), 32'd19);
        chk("len20_pops", 32'(n_pop), 32'd16);
        chk("len20_b17", 32'(e_log[17]), {21'd0, 3'b000, 8'h1E});
        chk("len20_b18", 32'(e_log[18]), {21'd0, 3'b001, 8'h1F});
        chk("len20_dones", 32'(n_done), 32'd1);
        chk("len20_errs", {30'd0, err_nack, err_timeout}, 32'd0);

        // Reset during WDATA with the command held valid
        clear_model(-1, 1'b0, 8'h00);
        send(1'b0, 7'h50, 16'h0123, 5'd4, 1'b1);
        begin
            int k = 0;
            while (e_n < 4 && k < 500) begin
                @(negedge clock);
                k++;
            end
        end
        chk("mid_reached_wdata", 32'(e_n), 32'd4);
        chk("mid_held_not_ready", 32'(cmd_ready), 32'd0);
        @(posedge clock); #1;
        nreset = 1'b0;
        @(posedge clock); #1;
        chk("mid_eng_nreset", 32'(eng_nreset), 32'd0);
        chk("mid_ctrl", {20'd0, eng_read_mode, eng_do_start, eng_do_stop, eng_write_byte}, 32'd0);
        chk("mid_idle", {30'd0, busy, cmd_ready}, 32'b01);
        chk("mid_strobes", {29'd0, done, wr_pop, rd_valid}, 32'd0);
        clear_model(-1, 1'b0, 8'h00);
        @(posedge clock); #1;
        chk("mid_held_in_reset", 32'(busy), 32'd0);
        nreset = 1'b1;
        @(posedge clock); #1;
        chk("mid_reaccept_busy", 32'(busy), 32'd1);
        chk("mid_reaccept_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        wait_done("mid");
        chk("mid_nbytes", 32'(e_n), 32'd7);
        chk("mid_b3", 32'(e_log[3]), {21'd0, 3'b000, 8'h10});
        chk("mid_b6", 32'(e_log[6]), {21'd0, 3'b001, 8'h13});
        chk("mid_pops", 32'(n_pop), 32'd4);
        chk("mid_dones", 32'(n_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
